// File: rtl/cordic_rotation_engine.sv
// ============================================================================
//  Module      : cordic_rotation_engine
//  Description : Iterative rotation-mode CORDIC. Takes a signed 2.14 radian
//                angle and produces cos/sin in 2.14, one micro-rotation per
//                clock. Drives the address of an external arctangent ROM and
//                consumes its registered output (1-cycle read latency).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start, angle_in     - request and 2.14 angle (+/-pi/2 range)
//                rom_idx, rom_angle  - ROM address out, ROM data in
//                busy, done          - in-flight flag, 1-cycle result strobe
//                cos_out, sin_out    - 2.14 results, held until next done
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_rotation_engine #(
    parameter int                              FIXED_WIDTH = 16,
    parameter int                              ITERATIONS  = 9,
    parameter logic signed [FIXED_WIDTH-1:0]   K_INIT      = 16'sd9949
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic signed [FIXED_WIDTH-1:0]      angle_in,
    output logic [$clog2(ITERATIONS)-1:0]      rom_idx,
    input  logic signed [FIXED_WIDTH-1:0]      rom_angle,
    output logic                               busy,
    output logic                               done,
    output logic signed [FIXED_WIDTH-1:0]      cos_out,
    output logic signed [FIXED_WIDTH-1:0]      sin_out
);

    localparam int                IDX_W    = $clog2(ITERATIONS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_ROTATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                         state_q;
    logic signed [FIXED_WIDTH-1:0]  x_q, y_q, z_q;
    logic signed [FIXED_WIDTH-1:0]  x_d, y_d, z_d;
    logic signed [FIXED_WIDTH-1:0]  x_sh, y_sh;
    logic [IDX_W-1:0]               iter_q;
    logic [IDX_W-1:0]               rom_idx_q;
    logic [IDX_W-1:0]               rom_idx_d;
    logic [IDX_W:0]                 idx_ahead;
    logic                           busy_q;
    logic                           done_q;
    logic signed [FIXED_WIDTH-1:0]  cos_q, sin_q;

    // One micro-rotation on the current state. z==0 rotates in the positive
    // direction. All arithmetic wraps at FIXED_WIDTH.
    always_comb begin
        x_sh = x_q >>> iter_q;
        y_sh = y_q >>> iter_q;
        if (!z_q[FIXED_WIDTH-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - rom_angle;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + rom_angle;
        end
    end

    // The ROM answers one cycle late, so the address runs two entries ahead
    // of the rotation that is currently consuming ROM data. Clamp at the
    // last entry; the extra headroom bit keeps iter+2 from wrapping.
    always_comb begin
        idx_ahead = {1'b0, iter_q} + (IDX_W+1)'(2);
        if (idx_ahead > {1'b0, LAST_IDX}) begin
            rom_idx_d = LAST_IDX;
        end else begin
            rom_idx_d = idx_ahead[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            iter_q    <= '0;
            rom_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cos_q     <= '0;
            sin_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x_q       <= K_INIT;
                        y_q       <= '0;
                        z_q       <= angle_in;
                        iter_q    <= '0;
                        rom_idx_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_PRIME;
                    end else begin
                        state_q   <= S_IDLE;
                    end
                end

                // ROM is latching entry 0 this cycle; present entry 1 next.
                S_PRIME: begin
                    rom_idx_q <= IDX_W'(1);
                    state_q   <= S_ROTATE;
                end

                S_ROTATE: begin
                    x_q    <= x_d;
                    y_q    <= y_d;
                    z_q    <= z_d;
                    iter_q <= iter_q + IDX_W'(1);
                    if (iter_q == LAST_IDX) begin
                        cos_q     <= x_d;
                        sin_q     <= y_d;
                        rom_idx_q <= '0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        rom_idx_q <= rom_idx_d;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_idx = rom_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cos_out = cos_q;
    assign sin_out = sin_q;

endmodule

`default_nettype wire
